// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control unit with a writable control store,
// micro-PC sequencing (NEXT/JUMP/BZ/BNZ/CALL/RET/WAITZ/HALT), stall support and
// a sticky error flag.
// Optional feature macro: MSEQ_STACK_EN enables a STACK_DEPTH-entry return stack
// for CALL/RET. Without it, CALL and RET are illegal ops that halt with err=1.
// Microword layout: {ctrl[CTRL_W], next_addr[ADDR_W], seq_op[3]}.
module micro_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int CTRL_W      = 54,
    parameter int START_ADDR  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       z_flag,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [CTRL_W+ADDR_W+2:0]   prog_data,
    output logic [CTRL_W-1:0]          signal,
    output logic [ADDR_W-1:0]          upc,
    output logic                       busy,
    output logic                       halted,
    output logic                       err
);

    localparam int WORD_W = CTRL_W + ADDR_W + 3;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        OP_NEXT  = 3'd0,
        OP_JUMP  = 3'd1,
        OP_BZ    = 3'd2,
        OP_BNZ   = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5,
        OP_WAITZ = 3'd6,
        OP_HALT  = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    if (STACK_DEPTH < 1 || ADDR_W < 1) begin : g_bad_params
        $error("micro_sequencer: STACK_DEPTH and ADDR_W must be at least 1");
    end

    state_t                state;
    state_t                state_n;
    logic [WORD_W-1:0]     store [DEPTH];
    logic                  store_we;
    seq_op_t               cur_op;
    logic [ADDR_W-1:0]     cur_next;
    logic [ADDR_W-1:0]     upc_inc;
    logic [ADDR_W-1:0]     upc_n;
    logic                  err_n;
    logic [CTRL_W-1:0]     signal_n;

    // The store only accepts writes while the sequencer is not executing.
    assign store_we = prog_we && (state != S_RUN);

    assign cur_op   = seq_op_t'(store[upc][2:0]);
    assign cur_next = store[upc][ADDR_W+2:3];
    assign upc_inc  = upc + ADDR_W'(1);

    assign busy     = (state == S_RUN);
    assign halted   = (state == S_HALT);

`ifdef MSEQ_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0]     stack [STACK_DEPTH];
    logic [SP_W-1:0]       sp;
    logic [SP_W-1:0]       sp_n;
    logic                  push;
    logic [IDX_W-1:0]      push_idx;
    logic [IDX_W-1:0]      top_idx;
    logic                  stack_full;
    logic                  stack_empty;

    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - SP_W'(1));
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
`endif

    // Control-store write port.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[prog_addr] <= prog_data;
        end
    end

    // Next state, next micro-PC and error flag from the current microword.
    always_comb begin
        state_n = state;
        upc_n   = upc;
        err_n   = err;
`ifdef MSEQ_STACK_EN
        sp_n    = sp;
        push    = 1'b0;
`endif
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n = S_RUN;
                    upc_n   = ADDR_W'(START_ADDR);
                    err_n   = 1'b0;
`ifdef MSEQ_STACK_EN
                    sp_n    = '0;
`endif
                end
            end
            S_RUN: begin
                if (!stall) begin
                    unique case (cur_op)
                        OP_NEXT:  upc_n = upc_inc;
                        OP_JUMP:  upc_n = cur_next;
                        OP_BZ:    upc_n = z_flag ? cur_next : upc_inc;
                        OP_BNZ:   upc_n = z_flag ? upc_inc : cur_next;
                        OP_WAITZ: upc_n = z_flag ? upc_inc : upc;
                        OP_HALT:  state_n = S_HALT;
`ifdef MSEQ_STACK_EN
                        OP_CALL: begin
                            if (stack_full) begin
                                state_n = S_HALT;
                                err_n   = 1'b1;
                            end else begin
                                push  = 1'b1;
                                sp_n  = sp + SP_W'(1);
                                upc_n = cur_next;
                            end
                        end
                        OP_RET: begin
                            if (stack_empty) begin
                                state_n = S_HALT;
                                err_n   = 1'b1;
                            end else begin
                                sp_n  = sp - SP_W'(1);
                                upc_n = stack[top_idx];
                            end
                        end
`else
                        OP_CALL, OP_RET: begin
                            state_n = S_HALT;
                            err_n   = 1'b1;
                        end
`endif
                    endcase
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control word registered alongside upc; a same-cycle store write to the
    // target address is forwarded so start+prog_we executes the new word.
    always_comb begin
        signal_n = '0;
        if (state_n == S_RUN) begin
            if (store_we && (prog_addr == upc_n)) begin
                signal_n = prog_data[WORD_W-1:ADDR_W+3];
            end else begin
                signal_n = store[upc_n][WORD_W-1:ADDR_W+3];
            end
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            upc    <= '0;
            signal <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            upc    <= upc_n;
            signal <= signal_n;
            err    <= err_n;
        end
    end

`ifdef MSEQ_STACK_EN
    // Return-stack pointer and entries; contents need no reset, sp does.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else begin
            sp <= sp_n;
            if (push) begin
                stack[push_idx] <= upc_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scenarios plus randomized traffic for
// micro_sequencer, checked every cycle against a behavioural model
// (word array + queue-based return stack). Honours MSEQ_STACK_EN.
module tb_micro_sequencer;

    localparam int ADDR_W      = 5;
    localparam int CTRL_W      = 54;
    localparam int START_ADDR  = 0;
    localparam int STACK_DEPTH = 4;
    localparam int W           = CTRL_W + ADDR_W + 3;
    localparam int DEPTH       = 1 << ADDR_W;

    localparam int OP_NEXT = 0, OP_JUMP = 1, OP_BZ = 2, OP_BNZ = 3;
    localparam int OP_CALL = 4, OP_RET = 5, OP_WAITZ = 6, OP_HALT = 7;

    logic              clk = 1'b0;
    logic              rst, start, stall, z_flag, prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [W-1:0]      prog_data;
    logic [CTRL_W-1:0] signal;
    logic [ADDR_W-1:0] upc;
    logic              busy, halted, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: 0 idle, 1 running, 2 halted
    logic [W-1:0]      m_mem [DEPTH];
    int                m_state = 0;
    int                m_upc = 0;
    logic [CTRL_W-1:0] m_sig = '0;
    logic              m_err = 1'b0;
    int                m_stk [$];

    micro_sequencer #(
        .ADDR_W(ADDR_W),
        .CTRL_W(CTRL_W),
        .START_ADDR(START_ADDR),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stall(stall),
        .z_flag(z_flag),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .signal(signal),
        .upc(upc),
        .busy(busy),
        .halted(halted),
        .err(err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [CTRL_W-1:0] c, input int nxt, input int op);
        logic [ADDR_W-1:0] n;
        logic [2:0]        o;
        n = nxt[ADDR_W-1:0];
        o = op[2:0];
        return {c, n, o};
    endfunction

    task automatic fault();
        m_err   = 1'b1;
        m_state = 2;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [W-1:0] wd;
        int op, nxt;
        if (m_state != 1 && prog_we) m_mem[prog_addr] = prog_data;
        if (rst) begin
            m_state = 0;
            m_upc   = 0;
            m_err   = 1'b0;
            m_stk.delete();
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1;
                m_upc   = START_ADDR;
                m_err   = 1'b0;
                m_stk.delete();
            end
        end else if (!stall) begin
            wd  = m_mem[m_upc];
            op  = int'(wd[2:0]);
            nxt = int'(wd[ADDR_W+2:3]);
            case (op)
                OP_NEXT:  m_upc = (m_upc + 1) % DEPTH;
                OP_JUMP:  m_upc = nxt;
                OP_BZ:    m_upc = z_flag ? nxt : (m_upc + 1) % DEPTH;
                OP_BNZ:   m_upc = z_flag ? (m_upc + 1) % DEPTH : nxt;
                OP_WAITZ: if (z_flag) m_upc = (m_upc + 1) % DEPTH;
                OP_HALT:  m_state = 2;
`ifdef MSEQ_STACK_EN
                OP_CALL: begin
                    if (m_stk.size() == STACK_DEPTH) fault();
                    else begin
                        m_stk.push_back((m_upc + 1) % DEPTH);
                        m_upc = nxt;
                    end
                end
                OP_RET: begin
                    if (m_stk.size() == 0) fault();
                    else m_upc = m_stk.pop_back();
                end
`else
                OP_CALL, OP_RET: fault();
`endif
                default: ;
            endcase
        end
        m_sig = (m_state == 1) ? m_mem[m_upc][W-1:ADDR_W+3] : '0;
    endtask

    task automatic tick(input logic st, input logic stl, input logic z, input logic we,
                        input logic [ADDR_W-1:0] a, input logic [W-1:0] d, input logic r);
        start = st; stall = stl; z_flag = z; prog_we = we;
        prog_addr = a; prog_data = d; rst = r;
        model_step();
        @(posedge clk);
        #1;
        check("upc", upc, m_upc);
        check("signal", signal, m_sig);
        check("busy", busy, m_state == 1);
        check("halted", halted, m_state == 2);
        check("err", err, m_err);
    endtask

    task automatic run(input logic z);
        tick(1'b0, 1'b0, z, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic hold();
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic load(input int a, input logic [W-1:0] d);
        tick(1'b0, 1'b0, 1'b0, 1'b1, a[ADDR_W-1:0], d, 1'b0);
    endtask

    task automatic go();
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [63:0] rnd;
        logic [CTRL_W-1:0] rc;
        int pick;

        // Reset state
        do_reset();
        check("rst_upc", upc, 0);
        check("rst_signal", signal, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        for (int i = 0; i < DEPTH; i++) load(i, mk('0, 0, OP_NEXT));

        // 1: NEXT then HALT
        load(0, mk(54'hA5, 0, OP_NEXT));
        load(1, mk(54'h3C, 0, OP_HALT));
        go();
        check("t1_upc0", upc, 0);
        check("t1_sig0", signal, 54'hA5);
        run(1'b0);
        check("t1_upc1", upc, 1);
        check("t1_sig1", signal, 54'h3C);
        run(1'b0);
        check("t1_halted", halted, 1);
        check("t1_sig_halt", signal, 0);

        // 2: BZ / BNZ on z_flag
        load(0, mk(54'h1, 17, OP_JUMP));
        load(17, mk(54'h11, 3, OP_BZ));
        load(18, mk(54'h12, 0, OP_HALT));
        load(3, mk(54'h13, 0, OP_HALT));
        go(); run(1'b0);
        check("t2_jump", upc, 17);
        run(1'b0);
        check("t2_bz_z0", upc, 18);
        run(1'b0);
        go(); run(1'b0); run(1'b1);
        check("t2_bz_z1", upc, 3);
        run(1'b0);
        load(17, mk(54'h11, 3, OP_BNZ));
        go(); run(1'b0); run(1'b1);
        check("t2_bnz_z1", upc, 18);
        run(1'b0);
        go(); run(1'b0); run(1'b0);
        check("t2_bnz_z0", upc, 3);
        run(1'b0);

        // 3: wrap 31->0 and stall freeze
        load(0, mk(54'h1, 31, OP_JUMP));
        load(31, mk(54'h31, 0, OP_NEXT));
        go(); run(1'b0);
        check("t3_at31", upc, 31);
        run(1'b0);
        check("t3_wrap", upc, 0);
        for (int i = 0; i < 3; i++) begin
            hold();
            check("t3_stall_upc", upc, 0);
            check("t3_stall_sig", signal, 54'h1);
        end
        run(1'b0);
        check("t3_resume", upc, 31);
        do_reset();
        load(0, mk(54'h7, 0, OP_HALT));
        go(); hold(); hold();
        check("t3_stall_halt", busy, 1);
        run(1'b0);
        check("t3_halt_after", halted, 1);

        // 4: WAITZ
        load(0, mk(54'h1, 4, OP_JUMP));
        load(4, mk(54'h44, 0, OP_WAITZ));
        load(5, mk(54'h45, 0, OP_HALT));
        go(); run(1'b0);
        for (int i = 0; i < 5; i++) begin
            run(1'b0);
            check("t4_waitz_hold", upc, 4);
        end
        run(1'b1);
        check("t4_waitz_go", upc, 5);
        run(1'b0);

        // 5: CALL/RET and stack faults
`ifdef MSEQ_STACK_EN
        load(0, mk(54'h1, 2, OP_JUMP));
        load(2, mk(54'h22, 8, OP_CALL));
        load(8, mk(54'h88, 0, OP_RET));
        load(3, mk(54'h33, 0, OP_HALT));
        go(); run(1'b0); run(1'b0);
        check("t5_call", upc, 8);
        run(1'b0);
        check("t5_ret", upc, 3);
        run(1'b0);
        check("t5_ret_noerr", err, 0);
        load(0, mk(54'h50, 0, OP_CALL));
        go();
        for (int i = 0; i < STACK_DEPTH; i++) run(1'b0);
        check("t5_full_busy", busy, 1);
        run(1'b0);
        check("t5_ovf_err", err, 1);
        check("t5_ovf_halt", halted, 1);
`else
        load(0, mk(54'h50, 8, OP_CALL));
        go(); run(1'b0);
        check("t5_call_err", err, 1);
        check("t5_call_halt", halted, 1);
        check("t5_call_upc", upc, 0);
`endif
        load(0, mk(54'h52, 0, OP_RET));
        go(); hold(); hold();
        check("t5_stall_fault", err, 0);
        run(1'b0);
        check("t5_ret_err", err, 1);
        go();
        check("t5_start_clr", err, 0);
        do_reset();

        // 6: reset mid-run, writes ignored in RUN, restart, start+write
        load(0, mk(54'h60, 0, OP_NEXT));
        load(1, mk(54'h61, 0, OP_NEXT));
        load(2, mk(54'h62, 0, OP_HALT));
        go(); run(1'b0);
        do_reset();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_sig", signal, 0);
        go();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, mk(54'hDEAD, 0, OP_HALT), 1'b0);
        check("t6_we_run", signal, 54'h61);
        go();
        check("t6_start_in_run", upc, 2);
        run(1'b0);
        go(); run(1'b0);
        check("t6_readback", signal, 54'h61);
        run(1'b0);
        check("t6_readback2", signal, 54'h62);
        run(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, mk(54'h77, 0, OP_HALT), 1'b0);
        check("t6_start_we", signal, 54'h77);
        run(1'b0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            rnd = {$urandom(), $urandom()};
            rc = rnd[CTRL_W-1:0];
            load(i, mk(rc, int'($urandom_range(DEPTH - 1)), int'($urandom_range(7))));
        end
        for (int i = 0; i < 2000; i++) begin
            rnd = {$urandom(), $urandom()};
            rc = rnd[CTRL_W-1:0];
            pick = int'($urandom_range(99));
            if (pick < 1) begin
                do_reset();
            end else begin
                tick(($urandom_range(99) < ((m_state == 1) ? 5 : 30)),
                     ($urandom_range(99) < 20),
                     1'($urandom_range(1)),
                     ($urandom_range(99) < 20),
                     ADDR_W'($urandom_range(DEPTH - 1)),
                     mk(rc, int'($urandom_range(DEPTH - 1)), int'($urandom_range(7))),
                     1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
